fp_mul_pipe: RTL and testbench

- Pipelined IEEE-754-style floating-point multiplier with a fixed 3-cycle latency; accepts one operand pair per clock.
- Sits directly upstream of the floating-point adder in the CNN datapath and produces the kernel-weight × activation products it sums.
- Output is split into sign, exponent and mantissa fields, the same layout the adder consumes, so both blocks share one format.
- Truncating (round-toward-zero), subnormals flushed to zero, parameterised field widths.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_unpack.sv | 27 ++
 rtl/fp_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the CNN datapath multiplier and adder.
package fp_pkg;

  localparam int FP_EXPONENT_WIDTH = 8;
  localparam int FP_MANTISSA_WIDTH = 23;
  localparam int FP_W              = 1 + FP_EXPONENT_WIDTH + FP_MANTISSA_WIDTH;
  localparam int FP_BIAS           = (1 << (FP_EXPONENT_WIDTH - 1)) - 1;
  localparam int FP_EMAX           = (1 << FP_EXPONENT_WIDTH) - 1;

  // Operand class. ZERO is encoded as 0 so a cleared pipeline register
  // naturally reads back as a +0 result.
  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_t;

  // Canonical quiet NaN for the default format: sign 0, exponent all ones,
  // fraction MSB set.
  localparam logic [FP_W-1:0] FP_CANON_NAN =
    {1'b0, {FP_EXPONENT_WIDTH{1'b1}}, 1'b1, {(FP_MANTISSA_WIDTH-1){1'b0}}};

  // Width-independent classification from three summary bits of an operand.
  // Subnormals (exponent 0, fraction nonzero) are flushed to ZERO.
  function automatic fp_class_t fp_classify(input logic exp_zero,
                                            input logic exp_max,
                                            input logic frac_nz);
    fp_class_t cls;
    if (exp_zero)      cls = FP_ZERO;
    else if (exp_max)  cls = frac_nz ? FP_NAN : FP_INF;
    else               cls = FP_NORMAL;
    return cls;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of a packed operand into sign, exponent, significand
// (with hidden bit) and class.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = FP_EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] op,
  output logic                                   sign,
  output logic [EXPONENT_WIDTH-1:0]              exponent,
  output logic [MANTISSA_WIDTH:0]                significand,
  output fp_class_t                              cls
);

  logic [MANTISSA_WIDTH-1:0] frac;

  // Field split and classification; non-normal operands carry a zero significand.
  always_comb begin
    sign        = op[EXPONENT_WIDTH+MANTISSA_WIDTH];
    exponent    = op[EXPONENT_WIDTH+MANTISSA_WIDTH-1 -: EXPONENT_WIDTH];
    frac        = op[MANTISSA_WIDTH-1:0];
    cls         = fp_classify(exponent == '0, &exponent, |frac);
    significand = (cls == FP_NORMAL) ? {1'b1, frac} : '0;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage truncating floating-point multiplier (flush-to-zero).
//
// Handshake: no backpressure. A pair is taken on every rising edge where
// in_valid=1; its result is presented with out_valid=1 on the outputs after
// the third rising edge counting the sampling edge. Results keep input order.
// Field outputs are meaningful only while out_valid=1, except right after
// reset where they read as zero.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = FP_EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] A_FP,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] B_FP,
  output logic                                   out_valid,
  output logic                                   sign,
  output logic [EXPONENT_WIDTH-1:0]              exponent,
  output logic [MANTISSA_WIDTH-1:0]              mantissa
);

  localparam int BIAS = (1 << (EXPONENT_WIDTH - 1)) - 1;
  localparam int EMAX = (1 << EXPONENT_WIDTH) - 1;
  localparam int EXW  = EXPONENT_WIDTH + 2;       // signed exponent arithmetic width
  localparam int PW   = 2 * (MANTISSA_WIDTH + 1); // full significand product width

  localparam logic signed [EXW-1:0] BIAS_X = EXW'(BIAS);
  localparam logic signed [EXW-1:0] EMAX_X = EXW'(EMAX);
  localparam logic signed [EXW-1:0] ONE_X  = EXW'(1);
  localparam logic signed [EXW-1:0] ZERO_X = '0;

  // Unpacked operands
  logic                      ua_sign, ub_sign;
  logic [EXPONENT_WIDTH-1:0] ua_exp, ub_exp;
  logic [MANTISSA_WIDTH:0]   ua_sig, ub_sig;
  fp_class_t                 ua_cls, ub_cls;

  fp_unpack #(.EXPONENT_WIDTH(EXPONENT_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH)) u_unpack_a (
    .op(A_FP), .sign(ua_sign), .exponent(ua_exp), .significand(ua_sig), .cls(ua_cls)
  );

  fp_unpack #(.EXPONENT_WIDTH(EXPONENT_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH)) u_unpack_b (
    .op(B_FP), .sign(ub_sign), .exponent(ub_exp), .significand(ub_sig), .cls(ub_cls)
  );

  // Pipeline state
  logic [2:0]              valid_sr;
  logic                    s1_sign;
  logic signed [EXW-1:0]   s1_exp_sum;
  logic [MANTISSA_WIDTH:0] s1_sig_a, s1_sig_b;
  fp_class_t               s1_cls_a, s1_cls_b;
  logic                    s2_sign;
  logic signed [EXW-1:0]   s2_exp;
  logic [PW-1:0]           s2_prod;
  fp_class_t               s2_cls;

  // Combinational helpers
  fp_class_t                 pair_cls;
  logic [PW-1:0]             norm;
  logic [MANTISSA_WIDTH-1:0] frac_n;
  logic signed [EXW-1:0]     exp_n;
  logic                      res_sign;
  logic [EXPONENT_WIDTH-1:0] res_exp;
  logic [MANTISSA_WIDTH-1:0] res_mant;
  logic                      unused_norm_bits;

  // Valid bit shift register; out_valid is its last tap.
  always_ff @(posedge clk) begin
    if (reset) valid_sr <= '0;
    else       valid_sr <= {valid_sr[1:0], in_valid};
  end

  assign out_valid = valid_sr[2];

  // Stage 1: register sign, widened exponent sum, significands and classes.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sign    <= 1'b0;
      s1_exp_sum <= '0;
      s1_sig_a   <= '0;
      s1_sig_b   <= '0;
      s1_cls_a   <= FP_ZERO;
      s1_cls_b   <= FP_ZERO;
    end else begin
      s1_sign    <= ua_sign ^ ub_sign;
      s1_exp_sum <= $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp});
      s1_sig_a   <= ua_sig;
      s1_sig_b   <= ub_sig;
      s1_cls_a   <= ua_cls;
      s1_cls_b   <= ub_cls;
    end
  end

  // Special-case resolution for the pair, highest precedence first.
  always_comb begin
    pair_cls = FP_NORMAL;
    if (s1_cls_a == FP_NAN || s1_cls_b == FP_NAN ||
        (s1_cls_a == FP_INF && s1_cls_b == FP_ZERO) ||
        (s1_cls_a == FP_ZERO && s1_cls_b == FP_INF))
      pair_cls = FP_NAN;
    else if (s1_cls_a == FP_INF || s1_cls_b == FP_INF)
      pair_cls = FP_INF;
    else if (s1_cls_a == FP_ZERO || s1_cls_b == FP_ZERO)
      pair_cls = FP_ZERO;
  end

  // Stage 2: register the full significand product and the unbiased-once exponent.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_cls  <= FP_ZERO;
    end else begin
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp_sum - BIAS_X;
      s2_prod <= PW'(s1_sig_a) * PW'(s1_sig_b);
      s2_cls  <= pair_cls;
    end
  end

  // Normalise by at most one position and pack, with overflow/underflow saturation.
  always_comb begin
    norm             = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    frac_n           = norm[PW-2 -: MANTISSA_WIDTH];
    exp_n            = s2_exp + (s2_prod[PW-1] ? ONE_X : ZERO_X);
    unused_norm_bits = ^{norm[PW-1], norm[PW-MANTISSA_WIDTH-2:0]};
    res_sign         = s2_sign;
    res_exp          = '0;
    res_mant         = '0;
    case (s2_cls)
      FP_NAN: begin
        res_sign = 1'b0;
        res_exp  = '1;
        res_mant = {1'b1, {(MANTISSA_WIDTH-1){1'b0}}};
      end
      FP_INF:  res_exp = '1;
      FP_ZERO: res_exp = '0;
      default: begin
        if (exp_n >= EMAX_X) begin
          res_exp = '1;
        end else if (exp_n > ZERO_X) begin
          res_exp  = exp_n[EXPONENT_WIDTH-1:0];
          res_mant = frac_n;
        end
      end
    endcase
  end

  // Stage 3: output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign     <= 1'b0;
      exponent <= '0;
      mantissa <= '0;
    end else begin
      sign     <= res_sign;
      exponent <= res_exp;
      mantissa <= res_mant;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vector table, streaming with
// a bubble, mid-stream reset, and randomized traffic against a reference model.
module tb_fp_mul_pipe;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int W   = 1 + EW + MW;
  localparam int LAT = 3; // rising edges from drive to visible result, sampling edge included

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  A_FP = '0;
  logic [W-1:0]  B_FP = '0;
  logic          out_valid;
  logic          sign;
  logic [EW-1:0] exponent;
  logic [MW-1:0] mantissa;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .A_FP(A_FP), .B_FP(B_FP),
    .out_valid(out_valid), .sign(sign), .exponent(exponent), .mantissa(mantissa)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          checking = 0;
  int          zero_left = 0;
  logic [W-1:0] exp_q[$];
  int unsigned  due_q[$];

  // ---------------- reference model ----------------
  // Value-level multiply: exact integer product of the significands, then the
  // leading one is located by search and the fraction is cut below it.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, lead;
    longint unsigned ma, mb, p;
    logic s;
    bit a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [22:0] f;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;                   // value = p * 2^(ea+eb-254-46)
    lead = 63;
    while (lead > 0 && p[lead] == 1'b0) lead--;
    e = ea + eb - 127 + (lead - 46);
    f = 23'(p >> (lead - 23));
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      r[30:23] = 8'h00;
    else if (k == 1) r[30:23] = 8'hFF;
    else if (k == 2) begin r[30:23] = 8'hFF; r[22:0] = '0; end
    else if (k <= 5) r[30:23] = 8'($urandom_range(1, 254));
    else             r[30:23] = 8'($urandom_range(64, 190));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    @(negedge clk);
    in_valid = v;
    A_FP = a;
    B_FP = b;
    if (v) begin
      exp_q.push_back(expv);
      due_q.push_back(cyc + LAT);
    end
  endtask

  task automatic drive_model(input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, a, b, ref_mul(a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    A_FP = '0;
    B_FP = '0;
    exp_q.delete();
    due_q.delete();
    zero_left = 3;
    checking = 1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / checker ----------------
  task automatic check_outputs();
    logic exp_v;
    logic [31:0] got, want;
    got = {sign, exponent, mantissa};
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    total++;
    if (out_valid !== exp_v) begin
      bad++;
      $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
    end
    if (exp_v) begin
      want = exp_q.pop_front();
      void'(due_q.pop_front());
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL result cyc=%0d got=%h want=%h", cyc, got, want);
      end
    end
    if (zero_left > 0) begin
      zero_left--;
      total++;
      if (out_valid !== 1'b0 || got !== 32'h0) begin
        bad++;
        $display("FAIL after_reset cyc=%0d got_valid=%b got=%h want_valid=0 want=00000000",
                 cyc, out_valid, got);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (checking) check_outputs();
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h40800000, 32'hBF800000, 32'hC0800000}; // 4 x -1
    vecs[1]  = '{32'h40200000, 32'hC0900000, 32'hC1340000}; // 2.5 x -4.5
    vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000}; // 1.5 x 1.5, back to back
    vecs[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000}; // overflow to +inf
    vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000}; // underflow to +0
    vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h00000000}; // subnormal flushed
    vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000}; // inf x 0
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000}; // NaN in
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000}; // -inf x 2
    vecs[9]  = '{32'h80000000, 32'h41400000, 32'h80000000}; // -0 x 12
    vecs[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000}; // 1 x 1
    vecs[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000}; // max x max

    do_reset();

    for (int i = 0; i < 12; i++) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].want);
    idle(4);

    // Streaming: 8 pairs with a one-cycle bubble after the 4th.
    for (int i = 0; i < 8; i++) begin
      drive_model(rand_op(), rand_op());
      if (i == 3) idle(1);
    end
    idle(4);

    // Reset with three pairs in flight; nothing stale may emerge.
    drive_model(32'h40400000, 32'h40400000);
    drive_model(32'h40A00000, 32'hC0000000);
    drive_model(32'h3F000000, 32'h3F000000);
    do_reset();
    drive(1'b1, 32'h40200000, 32'hC0900000, 32'hC1340000);
    idle(5);

    // Randomized traffic with random bubbles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_model(rand_op(), rand_op());
      else idle(1);
    end
    idle(5);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=200000ns", cyc);
    $fatal(1, "timeout");
  end

endmodule
